// File: rtl/ob_host_if_if.sv
// Host/order-book bundle for ob_host_if.
// master = the initiator block, slave = host plus order book.
interface ob_host_if_if #(
  parameter int CMD_W = 64,
  parameter int RSP_W = 64,
  parameter int OUT_W = 3
);
  logic             host_cmd_vld;
  logic [CMD_W-1:0] host_cmd;
  logic             host_cmd_rdy;
  logic             cmd_vld_r;
  logic [CMD_W-1:0] cmd_r;
  logic             cmd_full_r;
  logic             rsp_vld;
  logic [RSP_W-1:0] rsp;
  logic             rsp_accept;
  logic             host_rsp_vld;
  logic [RSP_W-1:0] host_rsp;
  logic             host_rsp_rdy;
  logic             drain;
  logic             drain_done;
  logic [OUT_W-1:0] outstanding;
  logic             err_timeout;
  logic             err_unexp;
  logic             err_clr;

  modport master (
    input  host_cmd_vld, host_cmd,
    output host_cmd_rdy,
    output cmd_vld_r, cmd_r,
    input  cmd_full_r,
    input  rsp_vld, rsp,
    output rsp_accept,
    output host_rsp_vld, host_rsp,
    input  host_rsp_rdy,
    input  drain,
    output drain_done,
    output outstanding, err_timeout, err_unexp,
    input  err_clr
  );

  modport slave (
    output host_cmd_vld, host_cmd,
    input  host_cmd_rdy,
    input  cmd_vld_r, cmd_r,
    output cmd_full_r,
    output rsp_vld, rsp,
    input  rsp_accept,
    input  host_rsp_vld, host_rsp,
    output host_rsp_rdy,
    output drain,
    input  drain_done,
    input  outstanding, err_timeout, err_unexp,
    output err_clr
  );
endinterface

// File: rtl/ob_host_if.sv
// Host-side order-book initiator: command stage, credit limit,
// response FIFO, watchdog, drain control and sticky error flags.
module ob_host_if #(
  parameter int CMD_W           = 64,
  parameter int RSP_W           = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_DEPTH       = 4,
  parameter int TIMEOUT         = 1024
) (
  input logic          clk,
  input logic          rst,
  ob_host_if_if.master bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPC = CW'(RSP_DEPTH);
  localparam logic [WW-1:0] TOC  = WW'(TIMEOUT);
  localparam logic [WW-1:0] TOM1 = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_alive;
  logic             r_stage_vld;
  logic [CMD_W-1:0] r_stage;
  logic             r_cmd_vld;
  logic [CMD_W-1:0] r_cmd;
  logic [OW-1:0]    r_outst;
  logic [OW-1:0]    w_outst_nxt;
  logic [WW-1:0]    r_wd;
  logic             r_err_to;
  logic             r_err_ux;
  logic [RSP_W-1:0] r_mem [RSP_DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  logic w_issue;
  logic w_cmd_hs;
  logic w_rsp_hs;
  logic w_pop;
  logic w_dec;
  logic w_unexp;
  logic w_to_set;
  logic w_full;
  logic w_empty;
  logic w_rdy;
  logic w_acc;

  assign w_full   = (r_cnt == DEPC);
  assign w_empty  = (r_cnt == '0);
  assign w_issue  = r_stage_vld & ~bus.cmd_full_r & (r_outst < MAXO);
  assign w_rdy    = r_alive & (r_state == S_RUN) & (~r_stage_vld | w_issue);
  assign w_acc    = r_alive & ~w_full;
  assign w_cmd_hs = bus.host_cmd_vld & w_rdy;
  assign w_rsp_hs = bus.rsp_vld & w_acc;
  assign w_pop    = ~w_empty & bus.host_rsp_rdy;
  assign w_dec    = w_rsp_hs & (r_outst != '0);
  assign w_unexp  = w_rsp_hs & (r_outst == '0);
  assign w_to_set = (r_outst != '0) & ~w_rsp_hs & (r_wd >= TOM1);

  assign bus.host_cmd_rdy = w_rdy;
  assign bus.cmd_vld_r    = r_cmd_vld;
  assign bus.cmd_r        = r_cmd;
  assign bus.rsp_accept   = w_acc;
  assign bus.host_rsp_vld = ~w_empty;
  assign bus.host_rsp     = r_mem[r_rd];
  assign bus.drain_done   = (r_state == S_DONE);
  assign bus.outstanding  = r_outst;
  assign bus.err_timeout  = r_err_to;
  assign bus.err_unexp    = r_err_ux;

  always_comb begin
    w_outst_nxt = r_outst;
    if (w_issue && !w_dec)
      w_outst_nxt = r_outst + 1'b1;
    else if (w_dec && !w_issue)
      w_outst_nxt = r_outst - 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (bus.drain) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.drain)
          w_state_nxt = S_RUN;
        else if (!r_stage_vld && r_outst == '0 && w_empty)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!bus.drain) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_alive     <= 1'b0;
      r_stage_vld <= 1'b0;
      r_stage     <= '0;
      r_cmd_vld   <= 1'b0;
      r_cmd       <= '0;
      r_outst     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_alive   <= 1'b1;
      r_cmd_vld <= w_issue;
      r_outst   <= w_outst_nxt;
      if (w_issue) r_cmd <= r_stage;
      if (w_cmd_hs) begin
        r_stage_vld <= 1'b1;
        r_stage     <= bus.host_cmd;
      end else if (w_issue) begin
        r_stage_vld <= 1'b0;
      end
    end
  end

  // Watchdog saturates at TIMEOUT; a set in the clear cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd     <= '0;
      r_err_to <= 1'b0;
      r_err_ux <= 1'b0;
    end else begin
      if (r_outst == '0 || w_rsp_hs)
        r_wd <= '0;
      else if (r_wd != TOC)
        r_wd <= r_wd + 1'b1;
      r_err_to <= w_to_set | (r_err_to & ~bus.err_clr);
      r_err_ux <= w_unexp | (r_err_ux & ~bus.err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_rsp_hs) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_rsp_hs && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_rsp_hs)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rsp_hs) r_mem[r_wr] <= bus.rsp;
  end

endmodule
